// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO read-side drain engine.
// State encoding and skid-buffer depth.
package fifo_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_FLUSH = ST_FLUSH
  } state_t;

endpackage

// File: rtl/fifo_drain_if.sv
// Valid/ready stream carrying drained FIFO words downstream.
// master drives valid/data, slave drives ready.
interface fifo_drain_if #(
  parameter int WIDTH = 8
);

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer absorbing the FIFO read latency.
// A write with a simultaneous read at full occupancy lands in the freed slot.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic             r_head;
  logic [1:0]       r_occ;
  logic             w_tail;

  // head+occ mod 2; at occ=2 this is the slot the read frees
  assign w_tail = r_head ^ r_occ[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++)
        r_mem[i] <= '0;
      r_head <= 1'b0;
      r_occ  <= 2'd0;
    end else if (i_clr) begin
      r_head <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (i_wr)
        r_mem[w_tail] <= i_data;
      if (i_rd)
        r_head <= ~r_head;
      r_occ <= r_occ + {1'b0, i_wr}
                     - {1'b0, i_rd};
    end
  end

  assign o_head = r_mem[r_head];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_drain.sv
// Read-side drain engine: FIFO pop, skid buffer, stream out, flush.
// Optional drained-word counter enabled by FIFO_DRAIN_CNT_EN.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  fifo_drain_if.master     m,
  output logic             busy,
  output logic             flush_done,
  output logic [CNT_W-1:0] drain_cnt
);

  state_t           r_state;
  logic             r_inflight;
  logic             r_busy;
  logic             r_flush_done;
  logic [1:0]       w_occ;
  logic [WIDTH-1:0] w_head;
  logic             w_pop;
  logic             w_wr;
  logic             w_done;
  logic [2:0]       w_need;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_wr   (w_wr),
    .i_rd   (w_pop),
    .i_clr  (flush),
    .i_data (fifo_dout),
    .o_head (w_head),
    .o_occ  (w_occ)
  );

  assign m.m_valid = (w_occ != 2'd0)
                  && (r_state != S_FLUSH);
  assign m.m_data  = w_head;
  assign w_pop     = m.m_valid && m.m_ready;
  // words landing during FLUSH are dropped
  assign w_wr      = r_inflight
                  && (r_state != S_FLUSH);
  assign w_need    = {1'b0, w_occ}
                   + {2'b0, r_inflight}
                   - {2'b0, w_pop};
  assign w_done    = (r_state == S_FLUSH)
                  && !flush
                  && fifo_empty
                  && !r_inflight;

  always_comb begin
    fifo_rd_en = 1'b0;
    unique case (1'b1)
      (r_state == S_RUN):
        fifo_rd_en = !fifo_empty
                  && (w_need < 3'd2);
      (r_state == S_FLUSH):
        fifo_rd_en = !fifo_empty;
      default:
        fifo_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_inflight   <= 1'b0;
      r_busy       <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_inflight   <= fifo_rd_en;
      r_flush_done <= 1'b0;
      if (flush) begin
        r_state <= S_FLUSH;
        r_busy  <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: if (en) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
          S_RUN: if (!en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          S_FLUSH: if (w_done) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_flush_done <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = r_busy;
  assign flush_done = r_flush_done;

`ifdef FIFO_DRAIN_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // cleared together with the flush_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_done)
      r_cnt <= '0;
    else if (w_pop)
      r_cnt <= r_cnt + 1'b1;
  end

  assign drain_cnt = r_cnt;
`else
  assign drain_cnt = '0;
`endif

endmodule
